// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU op codes, the $zero
// register number and bit positions inside the decoded id_ctrl bundle.
package id_ex_operand_stage_pkg;

  localparam int ALU_OP_LENGTH = 4;

  typedef enum logic [ALU_OP_LENGTH-1:0] {
    ALU_OP_NOP  = 4'd0,
    ALU_OP_ADDU = 4'd1,
    ALU_OP_SUBU = 4'd2,
    ALU_OP_AND  = 4'd3,
    ALU_OP_OR   = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_NOR  = 4'd6,
    ALU_OP_SLT  = 4'd7,
    ALU_OP_SLTU = 4'd8,
    ALU_OP_SLL  = 4'd9,
    ALU_OP_SRL  = 4'd10,
    ALU_OP_SRA  = 4'd11
  } alu_op_e;

  localparam int REG_ZERO = 0;

  // id_ctrl = {uses_rt, alu_src_imm, ext_sign, is_lui, mem_read, mem_write}
  localparam int CTRL_W           = 6;
  localparam int CTRL_USES_RT     = 5;
  localparam int CTRL_ALU_SRC_IMM = 4;
  localparam int CTRL_EXT_SIGN    = 3;
  localparam int CTRL_IS_LUI      = 2;
  localparam int CTRL_MEM_READ    = 1;
  localparam int CTRL_MEM_WRITE   = 0;

endpackage

// File: rtl/ex_fwd_mux.sv
// Combinational 3:1 operand bypass select: EX/MEM beats MEM/WB beats the
// latched register-file value; register $zero is never forwarded.
module ex_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_dst,
  input  logic [DATA_W-1:0] exmem_val,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_dst,
  input  logic [DATA_W-1:0] memwb_val,
  output logic [DATA_W-1:0] fwd_val
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_dst != ZERO_ADDR) && (exmem_dst == src);
  assign memwb_hit = memwb_reg_write && (memwb_dst != ZERO_ADDR) && (memwb_dst == src);

  always_comb begin
    // NOTE: default assigned first so no path leaves fwd_val unassigned (no latch).
    fwd_val = reg_val;
    if (exmem_hit) begin
      fwd_val = exmem_val;
    end else if (memwb_hit) begin
      fwd_val = memwb_val;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detection, plus the EX-stage
// operand front end (bypass muxes, immediate extension) feeding the ALU.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic [REG_AW-1:0]        id_dst,
  input  logic [DATA_W-1:0]        id_rs_val,
  input  logic [DATA_W-1:0]        id_rt_val,
  input  logic [15:0]              id_imm16,
  input  logic [ALU_OP_LENGTH-1:0] id_alu_op,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic                     id_reg_write,
  input  logic                     exmem_reg_write,
  input  logic [REG_AW-1:0]        exmem_dst,
  input  logic [DATA_W-1:0]        exmem_val,
  input  logic                     memwb_reg_write,
  input  logic [REG_AW-1:0]        memwb_dst,
  input  logic [DATA_W-1:0]        memwb_val,
  output logic                     hazard_stall,
  output logic [DATA_W-1:0]        SrcA,
  output logic [DATA_W-1:0]        SrcB,
  output logic [ALU_OP_LENGTH-1:0] alu_op,
  output logic [DATA_W-1:0]        store_data,
  output logic                     ex_valid,
  output logic [REG_AW-1:0]        ex_dst,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  // An all-zero stage_t is exactly a bubble (alu_op NOP, no side effects).
  typedef struct packed {
    logic                     valid;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     alu_src_imm;
    logic                     ext_sign;
    logic                     is_lui;
    logic [ALU_OP_LENGTH-1:0] alu_op;
    logic [REG_AW-1:0]        rs;
    logic [REG_AW-1:0]        rt;
    logic [REG_AW-1:0]        dst;
    logic [DATA_W-1:0]        rs_val;
    logic [DATA_W-1:0]        rt_val;
    logic [15:0]              imm16;
  } stage_t;

  stage_t id_stage;
  stage_t stage_d;
  stage_t stage_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    id_stage             = '0;
    id_stage.valid       = id_valid;
    id_stage.reg_write   = id_reg_write;
    id_stage.mem_read    = id_ctrl[CTRL_MEM_READ];
    id_stage.mem_write   = id_ctrl[CTRL_MEM_WRITE];
    id_stage.alu_src_imm = id_ctrl[CTRL_ALU_SRC_IMM];
    id_stage.ext_sign    = id_ctrl[CTRL_EXT_SIGN];
    id_stage.is_lui      = id_ctrl[CTRL_IS_LUI];
    id_stage.alu_op      = id_alu_op;
    id_stage.rs          = id_rs;
    id_stage.rt          = id_rt;
    id_stage.dst         = id_dst;
    id_stage.rs_val      = id_rs_val;
    id_stage.rt_val      = id_rt_val;
    id_stage.imm16       = id_imm16;
  end

  // Load in EX whose result an ID source needs: the value only exists after MEM.
  assign hazard_stall = id_valid && stage_q.valid && stage_q.mem_read &&
                        (stage_q.dst != ZERO_ADDR) &&
                        ((id_rs == stage_q.dst) ||
                         (id_ctrl[CTRL_USES_RT] && (id_rt == stage_q.dst)));

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (freeze) begin
      stage_d = stage_q;
    end else if (hazard_stall) begin
      stage_d = '0;
    end else begin
      stage_d = id_stage;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; only the pipeline
  // register itself is reset, there is no memory array to clear here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src             (stage_q.rs),
    .reg_val         (stage_q.rs_val),
    .exmem_reg_write (exmem_reg_write),
    .exmem_dst       (exmem_dst),
    .exmem_val       (exmem_val),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dst       (memwb_dst),
    .memwb_val       (memwb_val),
    .fwd_val         (fwd_rs)
  );

  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src             (stage_q.rt),
    .reg_val         (stage_q.rt_val),
    .exmem_reg_write (exmem_reg_write),
    .exmem_dst       (exmem_dst),
    .exmem_val       (exmem_val),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dst       (memwb_dst),
    .memwb_val       (memwb_val),
    .fwd_val         (fwd_rt)
  );

  always_comb begin
    SrcA = stage_q.is_lui ? '0 : fwd_rs;
    SrcB = fwd_rt;
    if (stage_q.alu_src_imm) begin
      if (stage_q.is_lui) begin
        SrcB = {stage_q.imm16, {(DATA_W-16){1'b0}}};
      end else if (stage_q.ext_sign) begin
        SrcB = {{(DATA_W-16){stage_q.imm16[15]}}, stage_q.imm16};
      end else begin
        SrcB = {{(DATA_W-16){1'b0}}, stage_q.imm16};
      end
    end
  end

  assign store_data   = fwd_rt;
  assign alu_op       = stage_q.alu_op;
  assign ex_valid     = stage_q.valid;
  assign ex_dst       = stage_q.dst;
  assign ex_reg_write = stage_q.reg_write;
  assign ex_mem_read  = stage_q.mem_read;
  assign ex_mem_write = stage_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, capture, bypass priority,
// load-use stall, immediate forms, flush/freeze behaviour.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // {uses_rt, alu_src_imm, ext_sign, is_lui, mem_read, mem_write}
  localparam logic [5:0] C_RR   = 6'b100000;
  localparam logic [5:0] C_LW   = 6'b011010;
  localparam logic [5:0] C_ORI  = 6'b010000;
  localparam logic [5:0] C_ADDI = 6'b011000;
  localparam logic [5:0] C_LUI  = 6'b010100;

  logic                     clk;
  logic                     rst_n;
  logic                     freeze;
  logic                     flush;
  logic                     id_valid;
  logic [REG_AW-1:0]        id_rs;
  logic [REG_AW-1:0]        id_rt;
  logic [REG_AW-1:0]        id_dst;
  logic [DATA_W-1:0]        id_rs_val;
  logic [DATA_W-1:0]        id_rt_val;
  logic [15:0]              id_imm16;
  logic [ALU_OP_LENGTH-1:0] id_alu_op;
  logic [5:0]               id_ctrl;
  logic                     id_reg_write;
  logic                     exmem_reg_write;
  logic [REG_AW-1:0]        exmem_dst;
  logic [DATA_W-1:0]        exmem_val;
  logic                     memwb_reg_write;
  logic [REG_AW-1:0]        memwb_dst;
  logic [DATA_W-1:0]        memwb_val;
  logic                     hazard_stall;
  logic [DATA_W-1:0]        SrcA;
  logic [DATA_W-1:0]        SrcB;
  logic [ALU_OP_LENGTH-1:0] alu_op;
  logic [DATA_W-1:0]        store_data;
  logic                     ex_valid;
  logic [REG_AW-1:0]        ex_dst;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     ex_mem_write;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .freeze          (freeze),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_dst          (id_dst),
    .id_rs_val       (id_rs_val),
    .id_rt_val       (id_rt_val),
    .id_imm16        (id_imm16),
    .id_alu_op       (id_alu_op),
    .id_ctrl         (id_ctrl),
    .id_reg_write    (id_reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_dst       (exmem_dst),
    .exmem_val       (exmem_val),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dst       (memwb_dst),
    .memwb_val       (memwb_val),
    .hazard_stall    (hazard_stall),
    .SrcA            (SrcA),
    .SrcB            (SrcB),
    .alu_op          (alu_op),
    .store_data      (store_data),
    .ex_valid        (ex_valid),
    .ex_dst          (ex_dst),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [31:0] rs_val,
                          input logic [31:0] rt_val, input logic [15:0] imm,
                          input logic [3:0] op, input logic [5:0] ctrl, input logic rw);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_dst       = dst;
    id_rs_val    = rs_val;
    id_rt_val    = rt_val;
    id_imm16     = imm;
    id_alu_op    = op;
    id_ctrl      = ctrl;
    id_reg_write = rw;
  endtask

  task automatic set_bypass(input logic ew, input logic [4:0] ed, input logic [31:0] ev,
                            input logic mw, input logic [4:0] md, input logic [31:0] mv);
    exmem_reg_write = ew;
    exmem_dst       = ed;
    exmem_val       = ev;
    memwb_reg_write = mw;
    memwb_dst       = md;
    memwb_val       = mv;
  endtask

  initial begin
    rst_n  = 1'b0;
    freeze = 1'b0;
    flush  = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, ALU_OP_NOP, 6'b0, 1'b0);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Power-on reset state
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_srca", SrcA, 0);
    check("rst_srcb", SrcB, 0);
    check("rst_stall", hazard_stall, 0);
    rst_n = 1'b1;
    tick();

    // addu $3,$1,$2 with rs_val=5, rt_val=7
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0, ALU_OP_ADDU, C_RR, 1'b1);
    tick();
    check("addu_srca", SrcA, 32'd5);
    check("addu_srcb", SrcB, 32'd7);
    check("addu_alu_op", alu_op, ALU_OP_ADDU);
    check("addu_ex_dst", ex_dst, 3);
    check("addu_ex_valid", ex_valid, 1);
    check("addu_reg_write", ex_reg_write, 1);

    // Asynchronous reset while a valid instruction sits in EX
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, ALU_OP_NOP, 6'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ex_valid", ex_valid, 0);
    check("arst_alu_op", alu_op, 0);
    check("arst_srca", SrcA, 0);
    check("arst_srcb", SrcB, 0);
    check("arst_ex_dst", ex_dst, 0);
    #2 rst_n = 1'b1;
    tick();

    // Bypass priority on rs; rt untouched then forwarded from MEM/WB
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 16'h0, ALU_OP_ADDU, C_RR, 1'b1);
    tick();
    set_bypass(1'b1, 5'd1, 32'h100, 1'b1, 5'd1, 32'h200);
    #1;
    check("fwd_exmem_prio", SrcA, 32'h100);
    check("fwd_rt_nomatch", SrcB, 32'h22);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", SrcA, 32'h200);
    memwb_dst = 5'd2;
    #1;
    check("fwd_rt_memwb", SrcB, 32'h200);
    check("store_data_fwd", store_data, 32'h200);
    check("fwd_rs_latched", SrcA, 32'h11);

    // $0 is never forwarded
    set_bypass(1'b1, 5'd0, 32'h100, 1'b1, 5'd0, 32'h200);
    drive_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 16'h0, ALU_OP_ADDU, C_RR, 1'b1);
    tick();
    check("fwd_zero_srca", SrcA, 0);
    check("fwd_zero_srcb", SrcB, 0);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Load-use: lw $4 then subu $5,$4,$6
    drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h1000, 32'h0, 16'd8, ALU_OP_ADDU, C_LW, 1'b1);
    tick();
    check("lw_mem_read", ex_mem_read, 1);
    drive_id(1'b1, 5'd4, 5'd6, 5'd5, 32'hDEAD, 32'h60, 16'h0, ALU_OP_SUBU, C_RR, 1'b1);
    #1;
    check("lu_stall", hazard_stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_mem_read", ex_mem_read, 0);
    check("lu_bubble_reg_write", ex_reg_write, 0);
    check("lu_bubble_alu_op", alu_op, 0);
    check("lu_stall_released", hazard_stall, 0);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4444);
    tick();
    check("lu_subu_valid", ex_valid, 1);
    check("lu_subu_op", alu_op, ALU_OP_SUBU);
    check("lu_subu_dst", ex_dst, 5);
    check("lu_subu_srca", SrcA, 32'h4444);
    check("lu_subu_srcb", SrcB, 32'h60);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Load-use via rt depends on uses_rt; $0 load never stalls
    drive_id(1'b1, 5'd1, 5'd7, 5'd7, 32'h0, 32'h0, 16'd0, ALU_OP_ADDU, C_LW, 1'b1);
    tick();
    drive_id(1'b1, 5'd1, 5'd7, 5'd8, 32'h0, 32'h0, 16'd1, ALU_OP_ADDU, C_ADDI, 1'b1);
    #1;
    check("lu_rt_unused", hazard_stall, 0);
    id_ctrl = C_RR;
    #1;
    check("lu_rt_used", hazard_stall, 1);
    id_valid = 1'b0;
    #1;
    check("lu_id_invalid", hazard_stall, 0);
    drive_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 16'd0, ALU_OP_ADDU, C_LW, 1'b1);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 16'd0, ALU_OP_ADDU, C_RR, 1'b1);
    #1;
    check("lu_zero_dst", hazard_stall, 0);

    // Immediate forms with imm16=0xFFFF, then lui
    drive_id(1'b1, 5'd1, 5'd2, 5'd2, 32'h1, 32'h0, 16'hFFFF, ALU_OP_OR, C_ORI, 1'b1);
    tick();
    check("imm_zext", SrcB, 32'h0000FFFF);
    drive_id(1'b1, 5'd1, 5'd2, 5'd2, 32'h1, 32'h0, 16'hFFFF, ALU_OP_ADDU, C_ADDI, 1'b1);
    tick();
    check("imm_sext", SrcB, 32'hFFFFFFFF);
    drive_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h99, 32'h0, 16'h1234, ALU_OP_ADDU, C_LUI, 1'b1);
    tick();
    check("lui_srca", SrcA, 0);
    check("lui_srcb", SrcB, 32'h12340000);

    // Flush wins over freeze
    flush  = 1'b1;
    freeze = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 5'd10, 32'h5, 32'h6, 16'h0, ALU_OP_SUBU, C_RR, 1'b1);
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_alu_op", alu_op, 0);
    check("flush_reg_write", ex_reg_write, 0);
    flush  = 1'b0;
    freeze = 1'b0;

    // Freeze holds registered outputs for 3 cycles; bypass stays live
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 32'h10, 32'h20, 16'h0, ALU_OP_ADDU, C_RR, 1'b1);
    tick();
    freeze = 1'b1;
    drive_id(1'b1, 5'd3, 5'd4, 5'd12, 32'h30, 32'h40, 16'h0, ALU_OP_SUBU, C_RR, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("frz%0d_valid", i), ex_valid, 1);
      check($sformatf("frz%0d_dst", i), ex_dst, 9);
      check($sformatf("frz%0d_op", i), alu_op, ALU_OP_ADDU);
      check($sformatf("frz%0d_srca", i), SrcA, 32'h10);
    end
    set_bypass(1'b1, 5'd1, 32'h777, 1'b0, 5'd0, 32'h0);
    #1;
    check("frz_bypass_live", SrcA, 32'h777);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    freeze = 1'b0;
    tick();
    check("unfrz_dst", ex_dst, 12);
    check("unfrz_op", alu_op, ALU_OP_SUBU);
    check("unfrz_srca", SrcA, 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
